bytebeat_voice_sched: RTL and testbench
=======================================

BYTEBEAT_VOICE_SCHED -- requirements
Module: bytebeat_voice_sched

Interface
REQ-001 Parameters SHALL be: NUM_VOICES, default 8, number of voices; TICK_DIV, default 512, clk cycles per sample tick (>=2); T_WIDTH, default 16, per-voice time counter width.
REQ-002 Clocking SHALL be one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 voice_en  input  NUM_VOICES  per-voice enable.
REQ-006 knob_a, knob_b, knob_c, knob_d  input  4 each  shared tone parameters.
REQ-007 req_vld  output  1  request to the shared bytebeat datapath valid.
REQ-008 req_rdy  input  1  datapath accepts the request.
REQ-009 req_voice  output  3  voice index of the request.
REQ-010 req_t  output  T_WIDTH  time value of that voice.
REQ-011 req_a..req_d  output  4 each  knobs latched at the round start.
REQ-012 rsp_vld  input  1  datapath result valid.
REQ-013 rsp_rdy  output  1  scheduler accepts the result.
REQ-014 rsp_pcm  input  8  result sample.
REQ-015 pcm  output  8*NUM_VOICES  per-voice sample registers; voice i occupies bits [8i+7:8i].
REQ-016 pcm_upd  output  NUM_VOICES  one-cycle pulse when pcm of voice i is written.
REQ-017 overrun  output  1  sticky flag: a tick arrived while a round was still in progress.

Function
REQ-018 The prescaler SHALL count from 0 to TICK_DIV-1 and wrap; tick is asserted in the cycle the count equals TICK_DIV-1.
REQ-019 FSM states SHALL be IDLE, SCAN, ISSUE, WAIT.
REQ-020 In IDLE on tick: latch voice_en into round_mask; latch the knobs into req_a..req_d; set the voice pointer to 0; go to SCAN.
REQ-021 At the same tick, each voice with round_mask=0 SHALL have its t counter cleared to 0 and its pcm cleared to 0x00 (no pcm_upd pulse).
REQ-022 SCAN SHALL evaluate one voice per cycle. If round_mask[ptr]=1, go to ISSUE. Otherwise increment ptr. After ptr=NUM_VOICES-1, go to IDLE.
REQ-023 ISSUE: req_vld=1 with req_voice=ptr and req_t=t[ptr]. Outputs SHALL stay stable until req_vld and req_rdy are both high in the same cycle; then go to WAIT.
REQ-024 WAIT: rsp_rdy=1. On rsp_vld: pcm[ptr]<=rsp_pcm, pulse pcm_upd[ptr] the next cycle, t[ptr]<=t[ptr]+1 (modulo 2^T_WIDTH). Then increment ptr and go to SCAN, or go to IDLE if ptr=NUM_VOICES-1.
REQ-025 req_vld SHALL be 0 outside ISSUE; rsp_rdy SHALL be 0 outside WAIT; a rsp_vld outside WAIT SHALL be ignored.
REQ-026 A tick while the state is not IDLE SHALL set overrun, SHALL be dropped, and SHALL NOT restart the round. overrun clears only on reset.
REQ-027 Changes to voice_en or the knobs mid-round SHALL take effect only at the next accepted tick.
REQ-028 A t counter at all-ones SHALL wrap to 0 on its next update.
REQ-029 With an empty round_mask, the round SHALL complete in NUM_VOICES SCAN cycles and issue no request.

Reset
REQ-030 On reset: the prescaler, all t counters, ptr, req_a..req_d, every pcm byte, pcm_upd, overrun, req_vld and rsp_rdy SHALL be 0, and the state SHALL be IDLE.
REQ-031 Reset asserted mid-round SHALL abandon any outstanding request or response with no pcm write. The first tick after reset deasserts SHALL occur TICK_DIV cycles later.

Verification
REQ-032 TICK_DIV=16, voice_en=0x01, datapath responds with rsp_pcm=t+3 after 2 cycles -> pcm[0] reads 0x03, 0x04, 0x05 on successive ticks; pcm_upd[0] pulses once per tick.
REQ-033 voice_en=0x81, req_rdy held low for 5 cycles -> req_vld, req_voice=0 and req_t stay stable throughout; voice 7 is issued only after voice 0's response.
REQ-034 TICK_DIV=16, response latency 20 cycles -> overrun=1 after the second tick; pcm[0] updates only once per completed round.
REQ-035 voice_en changed 0x03->0x01 mid-round -> voice 1 completes the current round; at the next tick pcm[1]=0x00 and t[1]=0.
REQ-036 Preload t[0]=0xFFFF (via 65535 rounds or force) -> the following request has req_t=0x0000.
REQ-037 Reset asserted while in WAIT, then rsp_vld=1 -> no pcm write; all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/bytebeat_voice_sched.sv
// Round-robin scheduler that shares one bytebeat datapath among NUM_VOICES voices.
// Each sample tick starts a round that issues one request per enabled voice, in order.
module bytebeat_voice_sched #(
    parameter int NUM_VOICES = 8,
    parameter int TICK_DIV   = 512,
    parameter int T_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_VOICES-1:0]   voice_en,
    input  logic [3:0]              knob_a,
    input  logic [3:0]              knob_b,
    input  logic [3:0]              knob_c,
    input  logic [3:0]              knob_d,
    output logic                    req_vld,
    input  logic                    req_rdy,
    output logic [2:0]              req_voice,
    output logic [T_WIDTH-1:0]      req_t,
    output logic [3:0]              req_a,
    output logic [3:0]              req_b,
    output logic [3:0]              req_c,
    output logic [3:0]              req_d,
    input  logic                    rsp_vld,
    output logic                    rsp_rdy,
    input  logic [7:0]              rsp_pcm,
    output logic [8*NUM_VOICES-1:0] pcm,
    output logic [NUM_VOICES-1:0]   pcm_upd,
    output logic                    overrun,
    output logic [1:0]              state_dbg
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // Handshakes: a request transfers on a cycle with req_vld && req_rdy, a
    // response on a cycle with rsp_vld && rsp_rdy; the request side holds its
    // outputs steady while req_vld is high and req_rdy is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         presc;
    logic                  tick;
    logic [PW-1:0]         ptr;
    logic [NUM_VOICES-1:0] round_mask;
    logic [T_WIDTH-1:0]    t_q [NUM_VOICES];
    logic                  last_voice;

    assign tick       = (presc == CW'(TICK_DIV - 1));
    assign last_voice = (ptr == PW'(NUM_VOICES - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) presc <= '0;
        else               presc <= presc + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (tick) state_nxt = SCAN;
            SCAN: begin
                if (round_mask[ptr]) state_nxt = ISSUE;
                else if (last_voice) state_nxt = IDLE;
            end
            ISSUE: if (req_rdy) state_nxt = WAIT;
            WAIT:  if (rsp_vld) state_nxt = last_voice ? IDLE : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_vld   = (state == ISSUE);
        rsp_rdy   = (state == WAIT);
        state_dbg = state;
    end

    assign req_voice = 3'(ptr);
    assign req_t     = t_q[ptr];

    // Round bookkeeping; voices left out of a round lose their time and sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            round_mask <= '0;
            req_a      <= '0;
            req_b      <= '0;
            req_c      <= '0;
            req_d      <= '0;
            pcm        <= '0;
            pcm_upd    <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) t_q[i] <= '0;
        end else begin
            pcm_upd <= '0;
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    round_mask <= voice_en;
                    req_a      <= knob_a;
                    req_b      <= knob_b;
                    req_c      <= knob_c;
                    req_d      <= knob_d;
                    ptr        <= '0;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (!voice_en[i]) begin
                            t_q[i]        <= '0;
                            pcm[8*i +: 8] <= 8'h00;
                        end
                    end
                end
                SCAN: if (!round_mask[ptr] && !last_voice) ptr <= ptr + PW'(1);
                WAIT: if (rsp_vld) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (ptr == PW'(i)) begin
                            pcm[8*i +: 8] <= rsp_pcm;
                            pcm_upd[i]    <= 1'b1;
                            t_q[i]        <= t_q[i] + T_WIDTH'(1);
                        end
                    end
                    if (!last_voice) ptr <= ptr + PW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bytebeat_voice_sched.sv
// Directed bench for bytebeat_voice_sched: a datapath responder, a round-level
// reference model checked every cycle, and hand-computed literal expectations.
module tb_bytebeat_voice_sched;
    localparam int NV = 8;
    localparam int TD = 16;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NV-1:0]   voice_en = '0;
    logic [3:0]      knob_a = '0, knob_b = '0, knob_c = '0, knob_d = '0;
    logic            req_vld, req_rdy, rsp_vld, rsp_rdy, overrun;
    logic [2:0]      req_voice;
    logic [TW-1:0]   req_t;
    logic [3:0]      req_a, req_b, req_c, req_d;
    logic [7:0]      rsp_pcm;
    logic [8*NV-1:0] pcm;
    logic [NV-1:0]   pcm_upd;
    logic [1:0]      state_dbg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bytebeat_voice_sched #(.NUM_VOICES(NV), .TICK_DIV(TD), .T_WIDTH(TW)) u_dut (
        .clk(clk), .reset(reset), .voice_en(voice_en),
        .knob_a(knob_a), .knob_b(knob_b), .knob_c(knob_c), .knob_d(knob_d),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_voice(req_voice), .req_t(req_t),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_pcm(rsp_pcm),
        .pcm(pcm), .pcm_upd(pcm_upd), .overrun(overrun), .state_dbg(state_dbg)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Datapath responder: answers each request with t + 3 + 16*voice.
    logic       resp_en = 1'b1;
    int         stall_len = 0, rsp_lat = 2, req_count = 0;
    int         ph = 0, stall_cnt = 0, lat = 0;
    logic [7:0] val;
    logic [TW-1:0] last_req_t;
    logic [2:0] last_req_voice;

    initial begin
        req_rdy = 1'b0;
        rsp_vld = 1'b0;
        rsp_pcm = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                ph = 0;
            end else if (reset) begin
                ph = 0; stall_cnt = 0; req_rdy = 1'b0; rsp_vld = 1'b0;
            end else begin
                case (ph)
                    0: begin
                        req_rdy = 1'b0;
                        if (req_vld) begin
                            if (stall_cnt < stall_len) begin
                                stall_cnt++;
                            end else begin
                                req_rdy = 1'b1;
                                stall_cnt = 0;
                                val = 8'(req_t) + 8'd3 + (8'(req_voice) << 4);
                                last_req_t = req_t;
                                last_req_voice = req_voice;
                                req_count++;
                                lat = 0;
                                ph = 1;
                            end
                        end
                    end
                    1: begin
                        req_rdy = 1'b0;
                        lat++;
                        if (lat >= rsp_lat) begin
                            rsp_vld = 1'b1;
                            rsp_pcm = val;
                            ph = 2;
                        end
                    end
                    default: begin
                        rsp_vld = 1'b0;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    // Reference model: voices expected this round, per-voice time and sample,
    // and whether the scheduler is still inside a round (busy).
    logic [7:0]    m_pcm [NV];
    logic [TW-1:0] m_t [NV];
    logic [NV-1:0] m_upd;
    logic [2:0]    exp_q[$];
    logic [3:0]    m_ka, m_kb, m_kc, m_kd;
    logic          m_ovr, m_busy, m_waiting, m_trailing, m_req_hold;
    logic          m_valid = 1'b0;
    int            m_trail, m_cnt;

    always @(negedge clk) begin
        logic [8*NV-1:0] exp_pcm;
        logic [NV-1:0]   nxt_upd;
        logic            cur_busy, tick, req_ok;
        logic [2:0]      v;
        if (m_valid) begin
            for (int i = 0; i < NV; i++) exp_pcm[8*i +: 8] = m_pcm[i];
            chk("pcm", 64'(pcm), 64'(exp_pcm));
            chk("pcm_upd", 64'(pcm_upd), 64'(m_upd));
            chk("overrun", 64'(overrun), 64'(m_ovr));
            chk("rsp_rdy", 64'(rsp_rdy), 64'(m_waiting));
            chk("idle", 64'(state_dbg == 2'd0), 64'(!m_busy));
            if (req_vld || m_req_hold) begin
                req_ok = req_vld && m_busy && !m_waiting && exp_q.size() > 0;
                if (req_ok)
                    req_ok = (req_voice == exp_q[0]) && (req_t == m_t[exp_q[0]]) &&
                             ({req_a, req_b, req_c, req_d} == {m_ka, m_kb, m_kc, m_kd});
                tests++;
                if (!req_ok) begin
                    fails++;
                    $display("FAIL req: vld=%b voice=%0d t=%0h knobs=%h expected vld=1 voice=%0d t=%0h knobs=%h",
                             req_vld, req_voice, req_t, {req_a, req_b, req_c, req_d},
                             (exp_q.size() > 0) ? exp_q[0] : 3'd0,
                             (exp_q.size() > 0) ? m_t[exp_q[0]] : '0, {m_ka, m_kb, m_kc, m_kd});
                end
            end
        end
        if (reset) begin
            for (int i = 0; i < NV; i++) begin m_pcm[i] = '0; m_t[i] = '0; end
            exp_q.delete();
            {m_ka, m_kb, m_kc, m_kd} = '0;
            m_upd = '0; m_ovr = 0; m_busy = 0; m_waiting = 0; m_trailing = 0;
            m_req_hold = 0; m_trail = 0; m_cnt = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            cur_busy = m_busy;
            tick = (m_cnt == TD - 1);
            m_cnt = tick ? 0 : m_cnt + 1;
            nxt_upd = '0;
            m_req_hold = req_vld && !req_rdy;
            if (m_waiting && rsp_vld) begin
                v = exp_q.pop_front();
                m_pcm[v] = rsp_pcm;
                m_t[v] = m_t[v] + 1'b1;
                nxt_upd[v] = 1'b1;
                m_waiting = 0;
                if (exp_q.size() == 0) begin
                    m_trail = NV - 1 - int'(v);
                    if (m_trail == 0) m_busy = 0;
                    else m_trailing = 1;
                end
            end else if (req_vld && req_rdy && m_busy && !m_waiting && exp_q.size() > 0) begin
                m_waiting = 1;
            end else if (m_trailing) begin
                m_trail--;
                if (m_trail == 0) begin m_trailing = 0; m_busy = 0; end
            end
            if (tick) begin
                if (cur_busy) begin
                    m_ovr = 1;
                end else begin
                    {m_ka, m_kb, m_kc, m_kd} = {knob_a, knob_b, knob_c, knob_d};
                    for (int i = 0; i < NV; i++) begin
                        if (voice_en[i]) exp_q.push_back(3'(i));
                        else begin m_t[i] = '0; m_pcm[i] = '0; end
                    end
                    m_busy = 1;
                    if (exp_q.size() == 0) begin m_trailing = 1; m_trail = NV; end
                end
            end
            m_upd = nxt_upd;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        req_count = 0;
        reset = 1'b0;
    endtask

    task automatic wait_count(input int n, input int budget, input string name);
        int i = 0;
        while (req_count < n && i < budget) begin step(); i++; end
        chk(name, 64'(req_count >= n), 64'(1));
    endtask

    task automatic wait_upd0(input int budget, input string name);
        int i = 0;
        while (!pcm_upd[0] && i < budget) begin step(); i++; end
        chk(name, 64'(pcm_upd[0]), 64'(1));
    endtask

    initial begin
        int n;
        // Reset state and basic round with one voice: t+3 each tick
        do_reset();
        chk("rst_pcm", 64'(pcm), 64'(0));
        chk("rst_ovr", 64'(overrun), 64'(0));
        chk("rst_req_vld", 64'(req_vld), 64'(0));
        chk("rst_rsp_rdy", 64'(rsp_rdy), 64'(0));
        chk("rst_knobs", 64'({req_a, req_b, req_c, req_d}), 64'(0));
        voice_en = 8'h01;
        {knob_a, knob_b, knob_c, knob_d} = 16'h1234;
        wait_upd0(40, "upd_wait_1");
        chk("pcm0_r1", 64'(pcm[7:0]), 64'h03);
        for (int k = 1; k < 3; k++) begin
            n = 0;
            repeat (TD) begin step(); if (pcm_upd[0]) n++; end
            chk("upd_per_tick", 64'(n), 64'(1));
            chk("pcm0_rk", 64'(pcm[7:0]), 64'(8'h03 + k));
        end

        // Stalled request on voice 0, then voice 7
        do_reset();
        voice_en = 8'h81;
        {knob_a, knob_b, knob_c, knob_d} = 16'hA5C3;
        stall_len = 5;
        n = 0;
        while (!req_vld && n < 40) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", 64'(req_vld), 64'(1));
            chk("stall_voice", 64'(req_voice), 64'(0));
            chk("stall_t", 64'(req_t), 64'(0));
            step();
        end
        wait_count(2, 60, "v7_issue");
        chk("v7_voice", 64'(last_req_voice), 64'(7));
        chk("v0_done_first", 64'(pcm[7:0]), 64'h03);
        stall_len = 0;

        // Slow datapath: second tick dropped, overrun sticky
        do_reset();
        chk("ovr_clear", 64'(overrun), 64'(0));
        voice_en = 8'h01;
        rsp_lat = 20;
        n = 0;
        repeat (60) begin step(); if (pcm_upd[0]) n++; end
        chk("slow_upds", 64'(n), 64'(1));
        chk("slow_ovr", 64'(overrun), 64'(1));
        wait_upd0(40, "slow_upd_wait");
        chk("slow_pcm_r2", 64'(pcm[7:0]), 64'h04);
        rsp_lat = 2;

        // voice_en change mid-round takes effect at the next tick
        do_reset();
        voice_en = 8'h03;
        wait_count(1, 40, "en_v0");
        voice_en = 8'h01;
        wait_count(2, 40, "en_v1");
        chk("en_v1_voice", 64'(last_req_voice), 64'(1));
        repeat (6) step();
        chk("en_pcm1_set", 64'(pcm[15:8]), 64'h13);
        wait_count(3, 40, "en_r2");
        chk("en_pcm1_clr", 64'(pcm[15:8]), 64'h00);
        voice_en = 8'h02;
        wait_count(4, 40, "en_r3");
        chk("en_v1_t", 64'(last_req_t), 64'(0));

        // t counter wraps from all-ones to zero
        do_reset();
        voice_en = 8'h01;
        wait_count(32, 700, "wrap_32");
        chk("wrap_t_max", 64'(last_req_t), 64'(5'h1F));
        wait_count(33, 40, "wrap_33");
        chk("wrap_t_zero", 64'(last_req_t), 64'(0));

        // Reset while waiting for a response, response arrives anyway
        do_reset();
        voice_en = 8'h01;
        n = 0;
        while (!rsp_rdy && n < 40) begin step(); n++; end
        chk("wait_reached", 64'(rsp_rdy), 64'(1));
        resp_en = 1'b0;
        rsp_vld = 1'b1;
        rsp_pcm = 8'hAA;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        chk("abandon_pcm", 64'(pcm), 64'(0));
        chk("abandon_upd", 64'(pcm_upd), 64'(0));
        chk("abandon_rsp_rdy", 64'(rsp_rdy), 64'(0));
        chk("abandon_req_vld", 64'(req_vld), 64'(0));
        chk("abandon_idle", 64'(state_dbg), 64'(0));
        rsp_vld = 1'b0;
        resp_en = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
